// File: rtl/uart_receiver_custom_if.sv
// Receive-side handshake bundle: byte, status flags and consumer ack.
// master = receiver (drives data/flags), slave = consumer (drives rx_ack).
interface uart_receiver_custom_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       data_ready;
  logic       overrun;
  logic       frame_err;
  logic       rx_busy;
  logic       rx_ack;

  modport master (
    output rx_data,
    output rx_valid,
    output data_ready,
    output overrun,
    output frame_err,
    output rx_busy,
    input  rx_ack
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  data_ready,
    input  overrun,
    input  frame_err,
    input  rx_busy,
    output rx_ack
  );
endinterface

// File: rtl/uart_receiver_custom.sv
// 8N1 UART receiver with 2-FF synchroniser, mid-bit sampling, ready/ack hold.
// Ports: clk, rst_n (async low), rx_serial_in (pad), bus (master modport).
module uart_receiver_custom #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_serial_in,
  uart_receiver_custom_if.master bus
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] clk_cnt, cnt_d;
  logic [2:0]    bit_cnt, bit_d;
  logic [7:0]    shreg, sh_d;
  logic          sync1, rx_s;
  logic          good, ferr;
  logic [7:0]    rx_data;
  logic          rx_valid, data_ready;
  logic          overrun, frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_serial_in;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_d;
      clk_cnt <= cnt_d;
      bit_cnt <= bit_d;
      shreg   <= sh_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = clk_cnt;
    bit_d   = bit_cnt;
    sh_d    = shreg;
    good    = 1'b0;
    ferr    = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (clk_cnt == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          // a high line at mid start bit is a glitch
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = clk_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (clk_cnt == LAST) begin
          cnt_d         = '0;
          sh_d[bit_cnt] = rx_s;
          if (bit_cnt == 3'd7) state_d = S_STOP;
          else                 bit_d   = bit_cnt + 3'd1;
        end else begin
          cnt_d = clk_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (clk_cnt == LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            good    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr    = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = clk_cnt + CW'(1);
        end
      end
      S_BREAK: begin
        // hold here until the line idles so a stuck-low line gives one error
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      data_ready <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid  <= good;
      frame_err <= ferr;
      if (good) rx_data <= sh_d;
      if (good)             data_ready <= 1'b1;
      else if (bus.rx_ack)  data_ready <= 1'b0;
      // ack coinciding with a new byte keeps overrun as is
      if (bus.rx_ack && !good)
        overrun <= 1'b0;
      else if (good && data_ready && !bus.rx_ack)
        overrun <= 1'b1;
    end
  end

  assign bus.rx_data    = rx_data;
  assign bus.rx_valid   = rx_valid;
  assign bus.data_ready = data_ready;
  assign bus.overrun    = overrun;
  assign bus.frame_err  = frame_err;
  assign bus.rx_busy    = (state != S_IDLE);

endmodule

// File: tb/tb_uart_receiver_custom.sv
// Directed bench for uart_receiver_custom: framing, latency, glitch,
// break, overrun/ack handshake and mid-frame reset.
module tb_uart_receiver_custom;
  localparam int CPB = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  int nvec = 0;
  int nfail = 0;
  int nval = 0;
  int nfe = 0;
  int v0, f0, k;

  uart_receiver_custom_if bus();

  uart_receiver_custom #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_serial_in (rx),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rx_valid)  nval++;
    if (bus.frame_err) nfe++;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] b, logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
  endtask

  task automatic ack_pulse();
    bus.rx_ack = 1'b1;
    tick(1);
    bus.rx_ack = 1'b0;
  endtask

  initial begin
    bus.rx_ack = 1'b0;
    tick(3);
    chk("rst_data", 32'(bus.rx_data), 0);
    chk("rst_valid", 32'(bus.rx_valid), 0);
    chk("rst_ready", 32'(bus.data_ready), 0);
    chk("rst_ovr", 32'(bus.overrun), 0);
    chk("rst_ferr", 32'(bus.frame_err), 0);
    chk("rst_busy", 32'(bus.rx_busy), 0);
    rst_n = 1'b1;
    tick(3);

    // 1: 0xA5 with latency measurement
    v0 = nval;
    f0 = nfe;
    fork
      send(8'hA5, 1'b1);
      begin
        k = 0;
        repeat (200) begin
          @(posedge clk);
          #1;
          k++;
          if (bus.rx_valid) break;
        end
      end
    join
    chk("a5_latency", 32'(k), 98);
    chk("a5_data", 32'(bus.rx_data), 32'hA5);
    chk("a5_pulses", 32'(nval - v0), 1);
    chk("a5_ready", 32'(bus.data_ready), 1);
    chk("a5_ferr", 32'(nfe - f0), 0);
    ack_pulse();
    chk("ack_clears_ready", 32'(bus.data_ready), 0);

    // 2: 0x00 then 0xFF with ack between
    v0 = nval;
    send(8'h00, 1'b1);
    chk("b2b_first", 32'(bus.rx_data), 32'h00);
    ack_pulse();
    send(8'hFF, 1'b1);
    chk("b2b_second", 32'(bus.rx_data), 32'hFF);
    chk("b2b_pulses", 32'(nval - v0), 2);
    chk("b2b_ovr", 32'(bus.overrun), 0);

    // 3: 3-cycle glitch
    v0 = nval;
    f0 = nfe;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    chk("glitch_busy_rise", 32'(bus.rx_busy), 1);
    k = 0;
    repeat (8) begin
      if (!bus.rx_busy) break;
      tick(1);
      k++;
    end
    chk("glitch_busy", 32'(bus.rx_busy), 0);
    chk("glitch_fall_le5", 32'(k <= 5), 1);
    tick(CPB);
    chk("glitch_valid", 32'(nval - v0), 0);
    chk("glitch_ferr", 32'(nfe - f0), 0);

    // 4: bad stop bit, then line held low
    v0 = nval;
    f0 = nfe;
    send(8'h3C, 1'b0);
    tick(50);
    chk("brk_ferr", 32'(nfe - f0), 1);
    chk("brk_valid", 32'(nval - v0), 0);
    chk("brk_ready", 32'(bus.data_ready), 1);
    chk("brk_data", 32'(bus.rx_data), 32'hFF);
    chk("brk_busy", 32'(bus.rx_busy), 1);
    rx = 1'b1;
    tick(4);
    chk("brk_exit", 32'(bus.rx_busy), 0);
    ack_pulse();
    send(8'h11, 1'b1);
    chk("after_brk_data", 32'(bus.rx_data), 32'h11);
    chk("after_brk_pulse", 32'(nval - v0), 1);

    // 5: overrun, then ack coinciding with the byte
    ack_pulse();
    v0 = nval;
    send(8'h12, 1'b1);
    send(8'h34, 1'b1);
    chk("ovr_set", 32'(bus.overrun), 1);
    chk("ovr_data", 32'(bus.rx_data), 32'h34);
    chk("ovr_ready", 32'(bus.data_ready), 1);
    chk("ovr_pulses", 32'(nval - v0), 2);
    ack_pulse();
    chk("ovr_ack_ovr", 32'(bus.overrun), 0);
    chk("ovr_ack_ready", 32'(bus.data_ready), 0);
    send(8'h12, 1'b1);
    chk("same_first_ready", 32'(bus.data_ready), 1);
    fork
      send(8'h34, 1'b1);
      begin
        tick(97);
        bus.rx_ack = 1'b1;
        tick(1);
        k = 32'(bus.rx_valid);
        bus.rx_ack = 1'b0;
      end
    join
    chk("same_align", 32'(k), 1);
    chk("same_ovr", 32'(bus.overrun), 0);
    chk("same_ready", 32'(bus.data_ready), 1);
    chk("same_data", 32'(bus.rx_data), 32'h34);

    // 6: reset during bit 4 of 0x5A
    ack_pulse();
    fork
      send(8'h5A, 1'b1);
      begin
        tick(CPB * 5 + 3);
        rst_n = 1'b0;
        tick(2);
        chk("mrst_data", 32'(bus.rx_data), 0);
        chk("mrst_ready", 32'(bus.data_ready), 0);
        chk("mrst_ovr", 32'(bus.overrun), 0);
        chk("mrst_busy", 32'(bus.rx_busy), 0);
        chk("mrst_valid", 32'(bus.rx_valid), 0);
        chk("mrst_ferr", 32'(bus.frame_err), 0);
      end
    join
    tick(3);
    rst_n = 1'b1;
    tick(3);
    v0 = nval;
    send(8'hC3, 1'b1);
    chk("post_rst_data", 32'(bus.rx_data), 32'hC3);
    chk("post_rst_ready", 32'(bus.data_ready), 1);
    chk("post_rst_pulse", 32'(nval - v0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
